// File: rtl/adder_arbiter_if.sv
// Request/result bundle for the shared-adder arbiter.
// Requesters and the result consumer sit on the master side; the arbiter is the slave.
interface adder_arbiter_if #(
    parameter int unsigned DW   = 5,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic [DW-1:0]      res_data;
    logic [IDW-1:0]     res_id;
    logic               res_ovf;
    logic               res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one signed DW-bit adder among NREQ requesters,
// with a 1-entry tagged result buffer and full-throughput valid/ready handshake.
module adder_arbiter #(
    parameter int unsigned DW   = 5,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input logic            clk,
    input logic            rst,
    adder_arbiter_if.slave bus
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [DW-1:0]  data_q;
    logic [IDW-1:0] id_q;
    logic           ovf_q;
    logic [IDW-1:0] ptr;

    logic           can_accept;
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic [NREQ-1:0] grant;
    logic           accept;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [DW-1:0]  sum;
    logic           ovf;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    assign can_accept = (state == S_EMPTY) || bus.res_ready;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = wrap_idx(ptr, k);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            grant[k] = found && can_accept && !rst && (32'(win) == k);
        end
    end

    assign accept        = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_a = bus.req_a[k*DW +: DW];
                sel_b = bus.req_b[k*DW +: DW];
            end
        end
    end

    assign sum = sel_a + sel_b;
    assign ovf = (sel_a[DW-1] == sel_b[DW-1]) && (sum[DW-1] != sel_a[DW-1]);

    // An accept takes priority over a drain, so drain+accept stays FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_EMPTY;
            data_q <= '0;
            id_q   <= '0;
            ovf_q  <= 1'b0;
            ptr    <= '0;
        end else begin
            if (accept) begin
                state  <= S_FULL;
                data_q <= sum;
                id_q   <= win;
                ovf_q  <= ovf;
                ptr    <= wrap_idx(win, 1);
            end else if ((state == S_FULL) && bus.res_ready) begin
                state <= S_EMPTY;
            end
        end
    end

    assign bus.res_valid = (state == S_FULL);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;
    assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of adder_arbiter against an arithmetic
// reference model of round-robin arbitration and signed addition.
module tb_adder_arbiter;

    localparam int unsigned DW   = 5;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic clk;
    logic rst;

    adder_arbiter_if #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

    adder_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned total;
    int unsigned passed;

    logic [NREQ-1:0] vld;
    logic [DW-1:0]   opa [NREQ];
    logic [DW-1:0]   opb [NREQ];
    logic            rr;

    logic            mvalid;
    logic [DW-1:0]   mdata;
    int              mid;
    logic            movf;
    int              mptr;
    int              last_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick();
        if (mvalid && !rr) return -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (vld[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = vld;
        bus.res_ready = rr;
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_a[i*DW +: DW] = opa[i];
            bus.req_b[i*DW +: DW] = opb[i];
        end
    endtask

    task automatic model_reset();
        mvalid = 1'b0;
        mdata  = '0;
        mid    = 0;
        movf   = 1'b0;
        mptr   = 0;
    endtask

    // Called one time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic tick(input string tag);
        int w;
        int ia, ib, s;
        logic [NREQ-1:0] exp_rdy;
        drive();
        #4;
        w = pick();
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        last_grant = w;
        @(posedge clk);
        if (w >= 0) begin
            ia     = $signed(opa[w]);
            ib     = $signed(opb[w]);
            s      = ia + ib;
            mdata  = s[DW-1:0];
            movf   = (s > (2**(DW-1)) - 1) || (s < -(2**(DW-1)));
            mid    = w;
            mvalid = 1'b1;
            mptr   = (w + 1) % NREQ;
        end else if (mvalid && rr) begin
            mvalid = 1'b0;
        end
        #1;
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'(mvalid));
        if (mvalid) begin
            check({tag, "_res_data"}, 32'(bus.res_data), 32'(mdata));
            check({tag, "_res_id"},   32'(bus.res_id),   32'(mid));
            check({tag, "_res_ovf"},  32'(bus.res_ovf),  32'(movf));
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        vld    = '1;
        rr     = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive();
        model_reset();

        // Reset state and no grant while rst is high
        #2;
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_data",  32'(bus.res_data),  32'd0);
        check("rst_id",    32'(bus.res_id),    32'd0);
        check("rst_ovf",   32'(bus.res_ovf),   32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_edge", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // Fill with 7 and hold, then reset mid-cycle
        vld = 4'b0010; opa[1] = 5'd3; opb[1] = 5'd4; rr = 1'b0;
        tick("fill7");
        check("fill7_data", 32'(bus.res_data), 32'd7);
        vld = '1;
        drive();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mrst_valid", 32'(bus.res_valid), 32'd0);
        check("mrst_data",  32'(bus.res_data),  32'd0);
        check("mrst_id",    32'(bus.res_id),    32'd0);
        check("mrst_ovf",   32'(bus.res_ovf),   32'd0);
        check("mrst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vld = '1; rr = 1'b1;
        tick("post_rst");
        check("post_rst_grant", 32'(last_grant), 32'd0);

        // Single request from requester 2: 5 + (-3)
        vld = 4'b0100; opa[2] = 5'd5; opb[2] = 5'b11101;
        tick("single");
        check("single_grant", 32'(last_grant), 32'd2);
        check("single_data",  32'(bus.res_data), 32'd2);
        check("single_id",    32'(bus.res_id),   32'd2);
        check("single_ovf",   32'(bus.res_ovf),  32'd0);

        // Move the pointer back to 0, then all requesters valid
        vld = 4'b1000; opa[3] = 5'd1; opb[3] = 5'd1;
        tick("align");
        vld = '1;
        for (int i = 0; i < int'(NREQ); i++) begin
            opa[i] = 5'(i + 1);
            opb[i] = 5'(2 * i);
        end
        for (int n = 0; n < 5; n++) begin
            tick("rr");
            check("rr_order", 32'(last_grant), 32'(n % 4));
            check("rr_id",    32'(bus.res_id), 32'(n % 4));
        end

        // Overflow and wrap through requester 1
        vld = 4'b0010;
        opa[1] = 5'b01111; opb[1] = 5'b00001;
        tick("ovf_pos");
        check("ovf_pos_data", 32'(bus.res_data), 32'h10);
        check("ovf_pos_ovf",  32'(bus.res_ovf),  32'd1);
        opa[1] = 5'b10000; opb[1] = 5'b11111;
        tick("ovf_neg");
        check("ovf_neg_data", 32'(bus.res_data), 32'h0f);
        check("ovf_neg_ovf",  32'(bus.res_ovf),  32'd1);
        opa[1] = 5'b11000; opb[1] = 5'b00111;
        tick("no_ovf");
        check("no_ovf_data", 32'(bus.res_data), 32'h1f);
        check("no_ovf_ovf",  32'(bus.res_ovf),  32'd0);

        // Backpressure while full, then drain and accept in the same cycle
        vld = 4'b1010; rr = 1'b0;
        opa[1] = 5'd2; opb[1] = 5'd2; opa[3] = 5'd6; opb[3] = 5'd3;
        for (int n = 0; n < 3; n++) begin
            tick("stall");
            check("stall_data", 32'(bus.res_data), 32'h1f);
            check("stall_id",   32'(bus.res_id),   32'd1);
        end
        rr = 1'b1;
        tick("unstall");
        check("unstall_grant", 32'(last_grant), 32'd3);
        check("unstall_valid", 32'(bus.res_valid), 32'd1);

        // Pointer holds across idle cycles
        vld = 4'b1000;
        tick("grant3");
        vld = '0;
        tick("idle");
        tick("idle");
        vld = 4'b0011;
        tick("after_idle");
        check("after_idle_grant", 32'(last_grant), 32'd0);

        // Randomized traffic; requesters hold operands until granted
        vld = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!vld[i] && ($urandom_range(0, 2) == 0)) begin
                    vld[i] = 1'b1;
                    opa[i] = DW'($urandom);
                    opb[i] = DW'($urandom);
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            tick("rand");
            if (last_grant >= 0) vld[last_grant] = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
